// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: receiver state encoding and a width helper for the bit counter.
package i2s_rx_pkg;

   typedef enum logic [1:0] {
      SEEK  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   // Smallest number of bits that can hold values 0 .. value-1.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res++;
      end
      return res;
   endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: input conditioning for the I2S pins plus rising-edge detect
// on the bit clock. All pins go through the same number of stages so that
// data and word select stay aligned with the detected sclk edge.
// I2S_RX_SYNC_EN defined  : two-flop synchronizer plus a retiming stage (3 clk).
// I2S_RX_SYNC_EN undefined: one register stage for same-clock sources (1 clk).
module i2s_rx_sync #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         edge_d,
   input  logic [W-1:0] lvl_d,
   output logic         edge_rise,
   output logic [W-1:0] lvl_q
);

`ifdef I2S_RX_SYNC_EN
   localparam int DEPTH = 3;
`else
   localparam int DEPTH = 1;
`endif

   // bit 0 carries the edge-detected pin, bits W:1 the level-only pins
   logic [W:0] stg [DEPTH];
   logic       edge_prev;

   // pin pipeline and previous-value register for the edge detector
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
         end
         edge_prev <= 1'b0;
      end else begin
         stg[0] <= {lvl_d, edge_d};
         for (int i = 1; i < DEPTH; i++) begin
            stg[i] <= stg[i-1];
         end
         edge_prev <= stg[DEPTH-1][0];
      end
   end

   assign edge_rise = stg[DEPTH-1][0] & ~edge_prev;
   assign lvl_q     = stg[DEPTH-1][W:1];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S slave receiver. Oversamples sclk/lrclk/sdi in the clk
// domain, aligns on a left-word MSB and presents each complete L/R pair with
// a one-clk write strobe. Input stage depth is selected by I2S_RX_SYNC_EN.
//
// state | meaning
// SEEK  | not aligned; waiting for the MSB of a left word
// LEFT  | receiving the left word
// RIGHT | receiving the right word; next left MSB completes the frame
module i2s_rx
   import i2s_rx_pkg::*;
#(
   parameter int DW       = 24,
   parameter int WORD_MAX = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sclk,
   input  logic          lrclk,
   input  logic          sdi,
   output logic [DW-1:0] l_sample,
   output logic [DW-1:0] r_sample,
   output logic          wr_en,
   input  logic          wr_ready,
   output logic          overflow,
   output logic          locked
);

   localparam int CW = clog2(WORD_MAX + 1);

   logic          sclk_rise;
   logic          lrclk_q;
   logic          sdi_q;

   state_t        state, state_nx;
   logic          ws1, ws2;
   logic [CW-1:0] cnt, cnt_nx;
   logic [DW-1:0] shift, shift_nx;
   logic [DW-1:0] left_hold;

   logic          word_start;
   logic          begin_word;
   logic          shift_on;
   logic          latch_left;
   logic          frame_done;
   logic          frame_err;
   logic          go_lock;

   i2s_rx_sync #(.W(2)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .edge_d    (sclk),
      .lvl_d     ({sdi, lrclk}),
      .edge_rise (sclk_rise),
      .lvl_q     ({sdi_q, lrclk_q})
   );

   // ws1 holds the channel of the bit being sampled, so a change between
   // ws1 and ws2 marks the MSB of a new word (one-bit-delayed word select)
   assign word_start = ws1 ^ ws2;

   // state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SEEK;
      end else begin
         state <= state_nx;
      end
   end

   // next-state, word framing and shift/counter next values
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      shift_nx   = shift;
      begin_word = 1'b0;
      shift_on   = 1'b0;
      latch_left = 1'b0;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      go_lock    = 1'b0;

      if (sclk_rise) begin
         unique case (state)
            SEEK: begin
               if (word_start && !ws1) begin
                  state_nx   = LEFT;
                  go_lock    = 1'b1;
                  begin_word = 1'b1;
               end
            end
            LEFT: begin
               if (word_start) begin
                  if (ws1) begin
                     state_nx   = RIGHT;
                     latch_left = 1'b1;
                     begin_word = 1'b1;
                  end else begin
                     frame_err = 1'b1;
                  end
               end else if (cnt == CW'(WORD_MAX)) begin
                  frame_err = 1'b1;
               end else begin
                  shift_on = 1'b1;
               end
            end
            RIGHT: begin
               if (word_start) begin
                  if (!ws1) begin
                     state_nx   = LEFT;
                     frame_done = 1'b1;
                     begin_word = 1'b1;
                  end else begin
                     frame_err = 1'b1;
                  end
               end else if (cnt == CW'(WORD_MAX)) begin
                  frame_err = 1'b1;
               end else begin
                  shift_on = 1'b1;
               end
            end
            default: begin
               frame_err = 1'b1;
            end
         endcase

         if (frame_err) begin
            state_nx = SEEK;
            cnt_nx   = '0;
            shift_nx = '0;
         end else if (begin_word) begin
            // word is left-justified: clearing first zero-fills short words
            shift_nx         = '0;
            shift_nx[DW-1]   = sdi_q;
            cnt_nx           = CW'(1);
         end else if (shift_on) begin
            // bits past DW find no matching position and are dropped
            for (int i = 0; i < DW; i++) begin
               if (int'(cnt) + i == DW - 1) begin
                  shift_nx[i] = sdi_q;
               end
            end
            cnt_nx = cnt + 1'b1;
         end
      end
   end

   // datapath, output registers and status flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         ws1       <= 1'b0;
         ws2       <= 1'b0;
         cnt       <= '0;
         shift     <= '0;
         left_hold <= '0;
         l_sample  <= '0;
         r_sample  <= '0;
         wr_en     <= 1'b0;
         overflow  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         cnt   <= cnt_nx;
         shift <= shift_nx;
         if (sclk_rise) begin
            ws1 <= lrclk_q;
            ws2 <= ws1;
         end
         if (latch_left) begin
            left_hold <= shift;
         end
         if (frame_done) begin
            if (wr_ready) begin
               wr_en    <= 1'b1;
               l_sample <= left_hold;
               r_sample <= shift;
            end else begin
               overflow <= 1'b1;
            end
         end
         if (go_lock) begin
            locked <= 1'b1;
         end
         if (frame_err) begin
            locked <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives I2S streams built from word lists and checks the
// receiver against a word-level model (channel runs -> frames).
module tb_i2s_rx;

   localparam int DW   = 24;
   localparam int WMAX = 32;
`ifdef I2S_RX_SYNC_EN
   localparam int LAT_NS = 36;
`else
   localparam int LAT_NS = 16;
`endif

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          sclk     = 1'b0;
   logic          lrclk    = 1'b0;
   logic          sdi      = 1'b0;
   logic          wr_ready = 1'b1;
   logic [DW-1:0] l_sample;
   logic [DW-1:0] r_sample;
   logic          wr_en;
   logic          overflow;
   logic          locked;

   i2s_rx #(.DW(DW), .WORD_MAX(WMAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .lrclk    (lrclk),
      .sdi      (sdi),
      .l_sample (l_sample),
      .r_sample (r_sample),
      .wr_en    (wr_en),
      .wr_ready (wr_ready),
      .overflow (overflow),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      int            k;
   } frame_t;

   bit            bch[$];
   bit            bd[$];
   bit            brdy[$];
   time           rise_t[$];
   frame_t        exp_q[$];
   logic [DW-1:0] mon_l[$];
   logic [DW-1:0] mon_r[$];
   time           mon_t[$];
   bit            exp_lock;
   bit            exp_ovf;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // capture every write strobe with its data and time
   always @(posedge clk) begin
      #1;
      if (wr_en === 1'b1) begin
         mon_l.push_back(l_sample);
         mon_r.push_back(r_sample);
         mon_t.push_back($time);
      end
   end

   // append a word of n bits, MSB first from v[31]; bits past 32 are random
   task automatic add_run(input bit ch, input int n, input logic [31:0] v, input bit rdy);
      for (int i = 0; i < n; i++) begin
         bch.push_back(ch);
         bd.push_back((i < 32) ? v[31-i] : 1'($urandom));
         brdy.push_back(rdy);
      end
   endtask

   // Word-level reference: split the visible bit stream into channel runs and
   // apply the framing rules run by run.
   task automatic compute_model(input int rel);
      bit            v[$];
      int            starts[$];
      bit            lock;
      logic [DW-1:0] lval, rval, w;
      int            b0, len;
      bit            ch;
      lock = 1'b0;
      lval = '0;
      rval = '0;
      exp_q.delete();
      exp_ovf = 1'b0;
      // the receiver's word-select history starts at 0 out of reset
      for (int k = rel; k < bch.size(); k++) begin
         v.push_back((k == rel) ? 1'b0 : bch[k]);
      end
      for (int j = 1; j < v.size(); j++) begin
         if (v[j] != v[j-1]) starts.push_back(j);
      end
      for (int s = 0; s < starts.size(); s++) begin
         b0  = starts[s];
         len = ((s + 1 < starts.size()) ? starts[s+1] : v.size()) - b0;
         ch  = v[b0];
         w   = '0;
         for (int i = 0; i < len && i < DW; i++) begin
            w[DW-1-i] = bd[rel+b0+i];
         end
         if (lock && ch == 1'b0) begin
            if (brdy[rel+b0]) exp_q.push_back('{lval, rval, rel + b0});
            else exp_ovf = 1'b1;
         end
         if (!lock && ch == 1'b0) lock = 1'b1;
         if (lock) begin
            if (ch == 1'b0) lval = w;
            else rval = w;
         end
         if (len > WMAX) lock = 1'b0;
      end
      exp_lock = lock;
   endtask

   // reset, play the queued stream (reset released before bit rel), compare
   task automatic run_phase(input string name, input int rel);
      int n;
      rst   = 1'b0;
      sclk  = 1'b0;
      lrclk = 1'b0;
      sdi   = 1'b0;
      repeat (3) @(negedge clk);
      chk({name, ".rst_l"},   32'(l_sample), 32'd0);
      chk({name, ".rst_r"},   32'(r_sample), 32'd0);
      chk({name, ".rst_wr"},  32'(wr_en),    32'd0);
      chk({name, ".rst_ovf"}, 32'(overflow), 32'd0);
      chk({name, ".rst_lck"}, 32'(locked),   32'd0);
      mon_l.delete();
      mon_r.delete();
      mon_t.delete();
      rise_t.delete();
      compute_model(rel);
      for (int k = 0; k < bch.size(); k++) begin
         @(negedge clk);
         sclk     = 1'b0;
         sdi      = bd[k];
         lrclk    = (k + 1 < bch.size()) ? bch[k+1] : bch[k];
         wr_ready = brdy[k];
         repeat (2) @(negedge clk);
         if (k == rel) rst = 1'b1;
         repeat (2) @(negedge clk);
         sclk = 1'b1;
         rise_t.push_back($time);
         repeat (3) @(negedge clk);
      end
      @(negedge clk);
      sclk = 1'b0;
      repeat (12) @(negedge clk);
      chk({name, ".n_frames"}, 32'(mon_l.size()), 32'(exp_q.size()));
      n = (mon_l.size() < exp_q.size()) ? mon_l.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.l[%0d]", name, i), 32'(mon_l[i]), 32'(exp_q[i].l));
         chk($sformatf("%s.r[%0d]", name, i), 32'(mon_r[i]), 32'(exp_q[i].r));
         chk($sformatf("%s.lat[%0d]", name, i), 32'(mon_t[i] - rise_t[exp_q[i].k]), 32'(LAT_NS));
      end
      chk({name, ".overflow"}, 32'(overflow), 32'(exp_ovf));
      chk({name, ".locked"},   32'(locked),   32'(exp_lock));
      bch.delete();
      bd.delete();
      brdy.delete();
   endtask

   initial begin
      // 24-bit samples in 32-bit slots, 64 sclk per frame
      add_run(1, 5, 32'hFFFFFFFF, 1);
      for (int f = 0; f < 4; f++) begin
         add_run(0, 32, 32'hABCDEF00, 1);
         add_run(1, 32, 32'h12345600, 1);
      end
      add_run(0, 4, 32'hABCDEF00, 1);
      run_phase("basic", 0);

      // reset released in the middle of the first right word
      add_run(0, 32, 32'h55555555, 1);
      add_run(1, 32, 32'h77777777, 1);
      for (int f = 0; f < 2; f++) begin
         add_run(0, 32, 32'hABCDEF00, 1);
         add_run(1, 32, 32'h12345600, 1);
      end
      add_run(0, 4, 32'h0, 1);
      run_phase("mid_reset", 48);

      // 16-bit words are left-justified with zero LSBs
      add_run(1, 3, 32'h0, 1);
      for (int f = 0; f < 3; f++) begin
         add_run(0, 16, 32'h80010000, 1);
         add_run(1, 16, 32'h7FFE0000, 1);
      end
      add_run(0, 2, 32'h0, 1);
      run_phase("short16", 0);

      // 32-bit words lose their low bits
      add_run(1, 3, 32'h0, 1);
      for (int f = 0; f < 3; f++) begin
         add_run(0, 32, 32'hDEADBEEF, 1);
         add_run(1, 32, 32'hCAFEF00D, 1);
      end
      add_run(0, 1, 32'hFFFFFFFF, 1);
      run_phase("long32", 0);

      // one frame refused by the sink
      add_run(1, 4, 32'h0, 1);
      add_run(0, 24, 32'h11111100, 1);
      add_run(1, 24, 32'h22222200, 1);
      add_run(0, 24, 32'h33333300, 0);
      add_run(1, 24, 32'h44444400, 1);
      add_run(0, 24, 32'h55555500, 1);
      add_run(1, 24, 32'h66666600, 1);
      add_run(0, 2, 32'h0, 1);
      run_phase("overflow", 0);

      // lrclk stuck low for 40 sclk
      add_run(1, 4, 32'h0, 1);
      add_run(0, 32, 32'hA1A2A300, 1);
      add_run(1, 32, 32'hB1B2B300, 1);
      add_run(0, 40, 32'hC1C2C3C4, 1);
      run_phase("stuck_low", 0);

      // same fault followed by recovery on the next left word
      add_run(1, 4, 32'h0, 1);
      add_run(0, 32, 32'hA1A2A300, 1);
      add_run(1, 32, 32'hB1B2B300, 1);
      add_run(0, 40, 32'hC1C2C3C4, 1);
      add_run(1, 32, 32'hD1D2D300, 1);
      add_run(0, 32, 32'hE1E2E300, 1);
      add_run(1, 32, 32'hF1F2F300, 1);
      add_run(0, 2, 32'h0, 1);
      run_phase("recover", 0);

      // random word lengths (some too long), data and sink readiness
      for (int p = 0; p < 3; p++) begin
         add_run(1, $urandom_range(1, 8), $urandom, 1);
         for (int f = 0; f < 6; f++) begin
            add_run(0, $urandom_range(8, 34), $urandom, ($urandom_range(0, 3) != 0));
            add_run(1, $urandom_range(8, 34), $urandom, 1);
         end
         add_run(0, 2, $urandom, 1);
         run_phase($sformatf("rand%0d", p), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
